// File: rtl/rps_match_engine.sv
// -----------------------------------------------------------------------------
// rps_match_engine
//
// Rock-paper-scissors match controller. Plays a first-to-ROUNDS_TO_WIN match
// capped at MAX_ROUNDS played rounds (draws count). The computer's gesture is
// reloaded when a round is armed, either from a free-running LFSR or from an
// adaptive predictor: a table indexed by the player's recent gestures, gated
// by a saturating confidence counter. Predictor state survives across matches
// and is cleared only by reset.
//
// Gesture encoding: rock=10, paper=01, scissors=00, 11=illegal/unknown.
//
// Ports:
//   clk              clock
//   reset            asynchronous, active-high reset
//   valid            single-cycle strobe qualifying player_gesture
//   player_gesture   gesture from the classifier
//   go               arm the next round from the inter-round wait
//   start            begin a new match once the current one is over
//   computer_gesture registered computer gesture for the current round
//   round_result     00 none, 01 player won, 10 computer won, 11 draw
//   player_score     rounds won by the player
//   computer_score   rounds won by the computer
//   round_count      rounds played this match
//   match_done       high while the match is over
//   winner           00 in play, 01 player, 10 computer, 11 neither
// -----------------------------------------------------------------------------
module rps_match_engine #(
    parameter int          ROUNDS_TO_WIN = 2,
    parameter int          MAX_ROUNDS    = 3,
    parameter int          SCORE_W       = 4,
    parameter int          HIST_DEPTH    = 2,
    parameter int          CONF_W        = 2,
    parameter logic [31:0] LFSR_SEED     = 32'h1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid,
    input  logic [1:0]         player_gesture,
    input  logic               go,
    input  logic               start,
    output logic [1:0]         computer_gesture,
    output logic [1:0]         round_result,
    output logic [SCORE_W-1:0] player_score,
    output logic [SCORE_W-1:0] computer_score,
    output logic [SCORE_W-1:0] round_count,
    output logic               match_done,
    output logic [1:0]         winner
);

    localparam int HIST_W = 2 * HIST_DEPTH;
    localparam int TBL_N  = 1 << HIST_W;

    localparam logic [1:0] ST_PLAY = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] G_UNKNOWN  = 2'b11;
    localparam logic [1:0] RES_NONE   = 2'b00;
    localparam logic [1:0] RES_PLAYER = 2'b01;
    localparam logic [1:0] RES_COMP   = 2'b10;
    localparam logic [1:0] RES_DRAW   = 2'b11;

    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
    localparam logic [CONF_W-1:0]  CONF_ONE  = CONF_W'(1);
    localparam logic [CONF_W-1:0]  CONF_MAX  = '1;

    // Gesture that beats g: rock->paper, paper->scissors, scissors->rock.
    function automatic logic [1:0] beater(input logic [1:0] g);
        case (g)
            2'b10:   beater = 2'b01;
            2'b01:   beater = 2'b00;
            default: beater = 2'b10;
        endcase
    endfunction

    logic [1:0]         r_state;
    logic [1:0]         r_comp;
    logic [1:0]         r_result;
    logic [SCORE_W-1:0] r_pscore;
    logic [SCORE_W-1:0] r_cscore;
    logic [SCORE_W-1:0] r_rounds;
    logic [31:0]        r_lfsr;
    logic [CONF_W-1:0]  r_conf;
    logic [HIST_W-1:0]  r_hist;
    logic [1:0]         r_table [TBL_N];

    logic               w_accept;
    logic               w_draw;
    logic               w_player_wins;
    logic [1:0]         w_pred;
    logic [1:0]         w_result;
    logic [SCORE_W-1:0] w_pscore_nxt;
    logic [SCORE_W-1:0] w_cscore_nxt;
    logic [SCORE_W-1:0] w_rounds_nxt;
    logic               w_match_end;
    logic [1:0]         w_random;
    logic [1:0]         w_reload;
    logic [HIST_W-1:0]  w_hist_nxt;
    logic               w_lfsr_fb;

    assign w_accept      = (r_state == ST_PLAY) && valid && (player_gesture != G_UNKNOWN);
    assign w_draw        = (player_gesture == r_comp);
    assign w_player_wins = (player_gesture == beater(r_comp));
    assign w_pred        = r_table[r_hist];
    assign w_lfsr_fb     = r_lfsr[31] ^ r_lfsr[29] ^ r_lfsr[25] ^ r_lfsr[24];

    // Newest gesture enters at the LSBs; the oldest falls off the top.
    generate
        if (HIST_DEPTH == 1) begin : g_hist1
            assign w_hist_nxt = player_gesture;
        end else begin : g_histn
            assign w_hist_nxt = {r_hist[HIST_W-3:0], player_gesture};
        end
    endgenerate

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_result     = RES_COMP;
        w_pscore_nxt = r_pscore;
        w_cscore_nxt = r_cscore;
        if (w_draw) begin
            w_result = RES_DRAW;
        end else if (w_player_wins) begin
            w_result     = RES_PLAYER;
            w_pscore_nxt = r_pscore + SCORE_ONE;
        end else begin
            w_cscore_nxt = r_cscore + SCORE_ONE;
        end
    end

    assign w_rounds_nxt = r_rounds + SCORE_ONE;
    assign w_match_end  = (w_pscore_nxt == SCORE_W'(ROUNDS_TO_WIN)) ||
                          (w_cscore_nxt == SCORE_W'(ROUNDS_TO_WIN)) ||
                          (w_rounds_nxt == SCORE_W'(MAX_ROUNDS));

    // Random pick skips the illegal code by falling back to the next LFSR pair.
    always_comb begin
        w_random = 2'b00;
        if (r_lfsr[1:0] != G_UNKNOWN) begin
            w_random = r_lfsr[1:0];
        end else if (r_lfsr[3:2] != G_UNKNOWN) begin
            w_random = r_lfsr[3:2];
        end
    end

    // Predict only when confident and the table has seen this history.
    assign w_reload = (r_conf[CONF_W-1] && (w_pred != G_UNKNOWN)) ? beater(w_pred) : w_random;

    // Match sequencing, scores and the LFSR.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_PLAY;
            r_comp   <= 2'b00;
            r_result <= RES_NONE;
            r_pscore <= '0;
            r_cscore <= '0;
            r_rounds <= '0;
            r_lfsr   <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[30:0], w_lfsr_fb};
            case (r_state)
                ST_PLAY: begin
                    if (w_accept) begin
                        r_pscore <= w_pscore_nxt;
                        r_cscore <= w_cscore_nxt;
                        r_rounds <= w_rounds_nxt;
                        r_result <= w_result;
                        r_state  <= w_match_end ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (go) begin
                        r_comp  <= w_reload;
                        r_state <= ST_PLAY;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        r_pscore <= '0;
                        r_cscore <= '0;
                        r_rounds <= '0;
                        r_result <= RES_NONE;
                        r_comp   <= w_reload;
                        r_state  <= ST_PLAY;
                    end
                end
                default: r_state <= ST_PLAY;
            endcase
        end
    end

    // Predictor: learns on every accepted round, kept across matches.
    // NOTE: the table is reset explicitly because a cleared table means "unknown", which gates prediction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_conf <= '0;
            r_hist <= '1;
            for (int i = 0; i < TBL_N; i++) begin
                r_table[i] <= G_UNKNOWN;
            end
        end else if (w_accept) begin
            if (w_pred != G_UNKNOWN) begin
                if (w_pred == player_gesture) begin
                    if (r_conf != CONF_MAX) r_conf <= r_conf + CONF_ONE;
                end else begin
                    if (r_conf != '0) r_conf <= r_conf - CONF_ONE;
                end
            end
            r_table[r_hist] <= player_gesture;
            r_hist          <= w_hist_nxt;
        end
    end

    always_comb begin
        winner = 2'b00;
        if (r_state == ST_DONE) begin
            if (r_pscore > r_cscore)      winner = 2'b01;
            else if (r_cscore > r_pscore) winner = 2'b10;
            else                          winner = 2'b11;
        end
    end

    assign computer_gesture = r_comp;
    assign round_result     = r_result;
    assign player_score     = r_pscore;
    assign computer_score   = r_cscore;
    assign round_count      = r_rounds;
    assign match_done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_rps_match_engine.sv
// -----------------------------------------------------------------------------
// tb_rps_match_engine
//
// Self-checking bench. A behavioural model of the match rules (plain integer
// scores, a gesture-history queue, an indexed prediction table) runs beside
// the DUT and every output is compared on each falling edge. Directed
// scenarios add hand-computed literal expectations, then a randomized phase
// (including mid-cycle resets) exercises the remaining space.
// -----------------------------------------------------------------------------
module tb_rps_match_engine;

    localparam int          RTW     = 2;
    localparam int          MAXR    = 3;
    localparam int          SW      = 4;
    localparam int          HD      = 2;
    localparam int          CW      = 2;
    localparam logic [31:0] SEED    = 32'h1;
    localparam int          TBL_N   = 4 ** HD;
    localparam int          CONF_MX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid = 1'b0;
    logic [1:0]    player_gesture = 2'b00;
    logic          go = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    computer_gesture;
    logic [1:0]    round_result;
    logic [SW-1:0] player_score;
    logic [SW-1:0] computer_score;
    logic [SW-1:0] round_count;
    logic          match_done;
    logic [1:0]    winner;

    int n_checks = 0;
    int n_pass   = 0;

    rps_match_engine #(
        .ROUNDS_TO_WIN(RTW), .MAX_ROUNDS(MAXR), .SCORE_W(SW),
        .HIST_DEPTH(HD), .CONF_W(CW), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .valid(valid), .player_gesture(player_gesture),
        .go(go), .start(start), .computer_gesture(computer_gesture),
        .round_result(round_result), .player_score(player_score),
        .computer_score(computer_score), .round_count(round_count),
        .match_done(match_done), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Gesture that beats g.
    function automatic logic [1:0] counter(input logic [1:0] g);
        if (g == 2'b10) return 2'b01;
        if (g == 2'b01) return 2'b00;
        return 2'b10;
    endfunction

    // ---------------- behavioural model ----------------
    typedef enum int { MS_PLAY, MS_WAIT, MS_DONE } mstate_t;

    mstate_t     m_st;
    int          m_ps, m_cs, m_rc, m_conf;
    logic [1:0]  m_res, m_comp;
    logic [31:0] m_lfsr;
    logic [1:0]  m_tbl [0:TBL_N-1];
    logic [1:0]  m_hist [$];

    function automatic int m_idx();
        int idx = 0;
        for (int i = 0; i < HD; i++) idx += int'(m_hist[i]) * (4 ** i);
        return idx;
    endfunction

    function automatic logic [1:0] m_pick();
        logic [1:0] t;
        t = m_tbl[m_idx()];
        if (m_conf >= (1 << (CW - 1)) && t != 2'b11) return counter(t);
        if (m_lfsr[1:0] != 2'b11) return m_lfsr[1:0];
        if (m_lfsr[3:2] != 2'b11) return m_lfsr[3:2];
        return 2'b00;
    endfunction

    task automatic m_reset();
        m_st = MS_PLAY; m_ps = 0; m_cs = 0; m_rc = 0; m_conf = 0;
        m_res = 2'b00; m_comp = 2'b00; m_lfsr = SEED;
        for (int i = 0; i < TBL_N; i++) m_tbl[i] = 2'b11;
        m_hist.delete();
        for (int i = 0; i < HD; i++) m_hist.push_back(2'b11);
    endtask

    task automatic m_step();
        logic [1:0] pick;
        int idx;
        pick = m_pick();
        case (m_st)
            MS_PLAY: if (valid && player_gesture != 2'b11) begin
                idx = m_idx();
                if (player_gesture == m_comp) m_res = 2'b11;
                else if (player_gesture == counter(m_comp)) begin m_ps++; m_res = 2'b01; end
                else begin m_cs++; m_res = 2'b10; end
                m_rc++;
                if (m_tbl[idx] != 2'b11) begin
                    if (m_tbl[idx] == player_gesture) m_conf = (m_conf < CONF_MX) ? m_conf + 1 : m_conf;
                    else                              m_conf = (m_conf > 0) ? m_conf - 1 : 0;
                end
                m_tbl[idx] = player_gesture;
                m_hist.push_front(player_gesture);
                void'(m_hist.pop_back());
                m_st = (m_ps == RTW || m_cs == RTW || m_rc == MAXR) ? MS_DONE : MS_WAIT;
            end
            MS_WAIT: if (go) begin m_comp = pick; m_st = MS_PLAY; end
            MS_DONE: if (start) begin
                m_ps = 0; m_cs = 0; m_rc = 0; m_res = 2'b00; m_comp = pick; m_st = MS_PLAY;
            end
            default: m_st = MS_PLAY;
        endcase
        m_lfsr = {m_lfsr[30:0], m_lfsr[31] ^ m_lfsr[29] ^ m_lfsr[25] ^ m_lfsr[24]};
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) m_reset();
        else       m_step();
    end

    always @(negedge clk) begin
        logic [1:0] exp_w;
        exp_w = 2'b00;
        if (m_st == MS_DONE) exp_w = (m_ps > m_cs) ? 2'b01 : (m_cs > m_ps) ? 2'b10 : 2'b11;
        check("model computer_gesture", 32'(computer_gesture), 32'(m_comp));
        check("model round_result",     32'(round_result),     32'(m_res));
        check("model player_score",     32'(player_score),     32'(m_ps));
        check("model computer_score",   32'(computer_score),   32'(m_cs));
        check("model round_count",      32'(round_count),      32'(m_rc));
        check("model match_done",       32'(match_done),       32'(m_st == MS_DONE));
        check("model winner",           32'(winner),           32'(exp_w));
    end

    // ---------------- stimulus ----------------
    // Apply inputs for exactly one rising edge; return 1 time unit after it.
    task automatic tick(input logic v, input logic [1:0] g, input logic go_i, input logic st_i);
        valid = v; player_gesture = g; go = go_i; start = st_i;
        @(posedge clk); #1;
        valid = 1'b0; go = 1'b0; start = 1'b0;
    endtask

    int k;

    initial begin
        reset = 1'b1;
        #12 reset = 1'b0;
        @(posedge clk); #1;

        // Reset values
        check("rst computer_gesture", 32'(computer_gesture), 0);
        check("rst scores", 32'({player_score, computer_score, round_count}), 0);
        check("rst done/winner", 32'({match_done, winner, round_result}), 0);

        // 1: rock vs reset scissors -> player wins, wait keeps gesture
        tick(1, 2'b10, 0, 0);
        check("t1 player_score", 32'(player_score), 1);
        check("t1 round_result", 32'(round_result), 1);
        check("t1 match_done", 32'(match_done), 0);
        tick(0, 2'b00, 0, 0);
        check("t1 gesture held", 32'(computer_gesture), 0);
        tick(0, 2'b00, 1, 0);
        check("t1 reload legal", 32'(computer_gesture != 2'b11), 1);

        // 2: player wins the second round -> match over
        tick(1, counter(computer_gesture), 0, 0);
        check("t2 player_score", 32'(player_score), 2);
        check("t2 match_done", 32'(match_done), 1);
        check("t2 winner", 32'(winner), 1);
        check("t2 round_count", 32'(round_count), 2);
        tick(1, 2'b10, 1, 0);
        tick(0, 2'b00, 1, 0);
        check("t2 frozen score", 32'({player_score, computer_score, round_count}), 32'({4'd2, 4'd0, 4'd2}));
        check("t2 frozen done", 32'(match_done), 1);
        tick(0, 2'b00, 0, 1);
        check("start clears", 32'({player_score, computer_score, round_count, round_result}), 0);
        check("start done low", 32'({match_done, winner}), 0);

        // 3: three draws
        for (int i = 0; i < 3; i++) begin
            tick(1, computer_gesture, 0, 0);
            check("t3 draw result", 32'(round_result), 3);
            if (i < 2) tick(0, 2'b00, 1, 0);
        end
        check("t3 scores", 32'({player_score, computer_score}), 0);
        check("t3 round_count", 32'(round_count), 3);
        check("t3 done/winner", 32'({match_done, winner}), 32'(3'b111));
        tick(0, 2'b00, 0, 1);

        // 5: illegal gesture ignored, go beats simultaneous valid
        tick(1, 2'b11, 0, 0);
        check("t5 illegal ignored", 32'({round_count, round_result, match_done}), 0);
        tick(1, computer_gesture, 0, 0);
        tick(1, 2'b10, 1, 0);
        check("t5 go+valid scores", 32'({player_score, computer_score}), 0);
        check("t5 go+valid rounds", 32'(round_count), 1);
        tick(1, computer_gesture, 0, 0);
        check("t5 back in play", 32'(round_count), 2);

        // 6: asynchronous reset asserted mid-WAIT, between edges
        #1 reset = 1'b1;
        #1;
        check("t6 async comp", 32'(computer_gesture), 0);
        check("t6 async counts", 32'({player_score, computer_score, round_count, round_result}), 0);
        check("t6 async done", 32'({match_done, winner}), 0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("t6 post comp", 32'(computer_gesture), 0);

        // 4: always paper; from the 5th accepted round the predictor locks on
        k = 0;
        for (int m = 0; m < 6; m++) begin
            for (int r = 0; r < MAXR; r++) begin
                if (!match_done) begin
                    tick(1, 2'b01, 0, 0);
                    k++;
                    if (!match_done) begin
                        tick(0, 2'b00, 1, 0);
                        if (k >= 5) check("t4 predicted after go", 32'(computer_gesture), 0);
                    end
                end
            end
            check("t4 match ended", 32'(match_done), 1);
            tick(0, 2'b00, 0, 1);
            if (k >= 5) check("t4 predicted after start", 32'(computer_gesture), 0);
        end

        // Randomized phase, occasional mid-cycle reset
        for (int n = 0; n < 1500; n++) begin
            valid          = ($urandom_range(0, 1) == 1);
            player_gesture = 2'($urandom_range(0, 3));
            go             = ($urandom_range(0, 9) < 3);
            start          = ($urandom_range(0, 9) < 2);
            if ($urandom_range(0, 299) == 0) begin
                #1 reset = 1'b1;
                #1 reset = 1'b0;
            end
            @(posedge clk); #1;
        end
        valid = 1'b0; go = 1'b0; start = 1'b0;
        @(negedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
